full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered full adder: computes a + b + c_in and presents {c_out, sum} from flip-flops one clock after the operands are sampled.
- Default configuration is the 1-bit full adder used as the arithmetic leaf cell in workshop datapaths.
- WIDTH > 1 builds a ripple-carry adder from a chain of combinational full-adder cells, followed by the same output register.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry in, weight 2^0.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0] of a + b + c_in.
- c_out  output  1  registered carry out, bit WIDTH of a + b + c_in.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low forces sum = 0 and c_out = 0 immediately, with no clock required.
  - Outputs hold 0 while rst_n is low.
  - Release is synchronous to clk; the first update occurs on the first rising edge with rst_n high.
- Arithmetic:
  - Unsigned addition; full result width WIDTH+1.
  - {c_out, sum} = a + b + c_in.
  - No saturation. Wrap is expressed solely through c_out.
- Carry chain:
  - cell i has inputs a[i], b[i], carry[i] and outputs sum[i], carry[i+1].
  - carry[0] = c_in; c_out = carry[WIDTH].
  - Per cell: s = a ^ b ^ ci; co = (a & b) | (a & ci) | (b & ci).
- Latency:
  - Inputs are sampled at rising edge N; the result is visible after edge N and stable until edge N+1.
  - Exactly 1 cycle latency, one result per cycle.
  - No handshake; every cycle is a valid operation.
- Outputs are driven only by flip-flops, with no combinational path from inputs to outputs.
- Reset asserted mid-operation: the in-flight result is discarded and outputs go to 0 at once.
- Boundary conditions:
  - All-ones operands with c_in = 1: sum = all-ones, c_out = 1.
  - Zero operands with c_in = 1: sum = 1, c_out = 0.
- X/Z on inputs is not required to be handled; outputs may go X.

Decomposition:
- No shared package needed. Design has no typedefs; WIDTH is the only constant.
- Sub-module full_adder_cell: purely combinational 1-bit cell with ports a, b, ci, s, co.
- Top instantiates WIDTH cells via a generate loop and adds the output register (sum, c_out) with async active-low reset.

Test Plan:
- Reset: hold rst_n = 0 with a = 1, b = 1, c_in = 1 and clk toggling -> sum = 0, c_out = 0 throughout. Assert rst_n = 0 between clock edges -> outputs clear without a clock edge.
- WIDTH=1 exhaustive truth table, one vector per cycle, checked one cycle after application:
  - a, b, c_in = 000 -> sum 0, c_out 0
  - 001 -> 1, 0
  - 010 -> 1, 0
  - 011 -> 0, 1
  - 100 -> 1, 0
  - 101 -> 0, 1
  - 110 -> 0, 1
  - 111 -> 1, 1
- Latency/hold, WIDTH=1:
  - Apply a = 1, b = 1, c_in = 0 at edge N -> outputs still show the previous result before edge N.
  - After edge N: sum = 0, c_out = 1, held for 3 idle cycles with inputs unchanged.
- Reset mid-stream: while streaming vectors, pulse rst_n low for half a cycle -> outputs 0 immediately; correct results resume from the first edge after release.
- WIDTH=4 wrap:
  - a = 15, b = 1, c_in = 0 -> sum = 0, c_out = 1.
  - a = 15, b = 15, c_in = 1 -> sum = 15, c_out = 1.
  - a = 0, b = 0, c_in = 1 -> sum = 1, c_out = 0.
- WIDTH=8 random: 1000 random a, b, c_in vectors, one per cycle -> {c_out, sum} equals a + b + c_in, compared one cycle later.

Source files
------------

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full-adder leaf cell; the ripple chain in full_adder is built from these.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle after sampling.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = c_in;

  // Carry ripples LSB to MSB; carry[WIDTH] becomes the registered c_out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_comb;
      c_out <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: three adder widths against an arithmetic reference model.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, c1, s1, co1;
  logic [3:0] a4, b4, s4;
  logic       c4, co4;
  logic [7:0] a8, b8, s8;
  logic       c8, co8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .sum(s1), .c_out(co1));
  full_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(c4), .sum(s4), .c_out(co4));
  full_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8), .sum(s8), .c_out(co8));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Unsigned sum truncated to w+1 bits (sum plus carry out).
  function automatic logic [15:0] ref_add(input int w, input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned r;
    r = a + b + c;
    return 16'(r & ((32'd1 << (w + 1)) - 1));
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_w1"}, 16'({co1, s1}), 16'd0);
    chk({tag, "_w4"}, 16'({co4, s4}), 16'd0);
    chk({tag, "_w8"}, 16'({co8, s8}), 16'd0);
  endtask

  initial begin
    logic [3:0] wa [3];
    logic [3:0] wb [3];
    logic       wc [3];
    logic [15:0] w4_exp [3];
    wa = '{4'd15, 4'd15, 4'd0};
    wb = '{4'd1,  4'd15, 4'd0};
    wc = '{1'b0,  1'b1,  1'b1};
    w4_exp = '{16'h10, 16'h1f, 16'h01};

    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = '1;   b4 = '1;   c4 = 1'b1;
    a8 = '1;   b8 = '1;   c8 = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    rst_n = 1'b1;

    // Truth table, width 1
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      @(negedge clk);
      chk($sformatf("tt_%0d", i), 16'({co1, s1}), ref_add(1, a1, b1, c1));
    end

    // Latency and hold: output still shows 1+1+1 until the next edge
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    #4;
    chk("lat_pre", 16'({co1, s1}), 16'b11);
    @(negedge clk);
    chk("lat_post", 16'({co1, s1}), 16'b10);
    repeat (3) begin
      @(negedge clk);
      chk("lat_hold", 16'({co1, s1}), 16'b10);
    end

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_w1", 16'({co1, s1}), 16'b10);

    // Width 4 wrap cases
    for (int i = 0; i < 3; i++) begin
      a4 = wa[i]; b4 = wb[i]; c4 = wc[i];
      @(negedge clk);
      chk($sformatf("w4_wrap_%0d", i), 16'({co4, s4}), w4_exp[i]);
      chk($sformatf("w4_model_%0d", i), 16'({co4, s4}), ref_add(4, a4, b4, c4));
    end

    // Width 8 random stream with a mid-stream reset pulse
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      if (i == 500) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
      chk("w8_rand", 16'({co8, s8}), ref_add(8, a8, b8, c8));
    end

    // Width 8 boundaries
    a8 = 8'hff; b8 = 8'hff; c8 = 1'b1;
    @(negedge clk);
    chk("w8_all_ones", 16'({co8, s8}), 16'h1ff);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b1;
    @(negedge clk);
    chk("w8_zero_cin", 16'({co8, s8}), 16'h001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
